fb_write_scheduler: RTL and testbench

//  Frame-level write scheduler for the 800x600 framebuffer (4 pixels per word, 120000 words).

---
 rtl/fb_write_scheduler_pkg.sv | 16 +
 rtl/fb_write_scheduler_rr_arbiter.sv | 52 +++++
 rtl/fb_write_scheduler.sv | 177 +++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_write_scheduler_pkg.sv
// Shared constants and FSM state type for the 800x600 framebuffer write path.
package fb_pkg;

  localparam int unsigned H_RES        = 800;
  localparam int unsigned V_RES        = 600;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned LINE_WORDS   = H_RES / PIX_PER_WORD;
  localparam int unsigned FB_DEPTH     = 120000;
  localparam int unsigned ADDR_W       = 17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upwards with wrap.
module rr_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] win;
  logic             found;

  always_comb begin
    gnt   = '0;
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PTR_W'((32'(ptr_q) + i) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end

    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (found) begin
      ptr_d = (32'(win) == N - 1) ? '0 : win + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Round-robin framebuffer write scheduler: pixel (x,y) -> word address + lane, frame completion.
// Optional FB_DROPCNT_EN builds a saturating counter of off-screen pixels on o_drop_cnt.
module fb_write_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PIX_W   = 4,
  parameter int unsigned H_RES   = fb_pkg::H_RES,
  parameter int unsigned V_RES   = fb_pkg::V_RES,
  parameter int unsigned ADDR_W  = fb_pkg::ADDR_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_frame_start,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*16-1:0]    i_x,
  input  logic [NUM_REQ*16-1:0]    i_y,
  input  logic [NUM_REQ*PIX_W-1:0] i_pix,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic                     o_we,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [4*PIX_W-1:0]       o_wdata,
  output logic [3:0]               o_lane_en,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic [15:0]              o_drop_cnt
);

  localparam int unsigned LINE_WORDS = H_RES / fb_pkg::PIX_PER_WORD;
  localparam int unsigned FRAME_PIX  = H_RES * V_RES;
  localparam int unsigned CNT_W      = $clog2(FRAME_PIX + 1);

  fb_pkg::fb_state_e state_q, state_d;
  logic              run;
  logic              transfer;
  logic [NUM_REQ-1:0] gnt;

  logic [15:0]       sel_x, sel_y;
  logic [PIX_W-1:0]  sel_pix;

  logic              s1_valid_q, s1_valid_d;
  logic [15:0]       s1_x_q, s1_x_d;
  logic [15:0]       s1_y_q, s1_y_d;
  logic [PIX_W-1:0]  s1_pix_q, s1_pix_d;

  logic              in_range;
  logic [ADDR_W-1:0] addr_calc;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4*PIX_W-1:0] wdata_q, wdata_d;
  logic [3:0]        lane_q, lane_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign run = (state_q == fb_pkg::ST_RUN);

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk (i_clk),
    .rst (i_rst),
    .en  (run),
    .clr (i_frame_start),
    .req (i_req),
    .gnt (gnt)
  );

  assign transfer = |gnt;

  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_pix = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_x   = i_x[16*k +: 16];
        sel_y   = i_y[16*k +: 16];
        sel_pix = i_pix[PIX_W*k +: PIX_W];
      end
    end
  end

  // S1: capture the granted pixel; a frame_start discards a same-cycle transfer.
  always_comb begin
    s1_valid_d = transfer && !i_frame_start;
    s1_x_d     = transfer ? sel_x   : s1_x_q;
    s1_y_d     = transfer ? sel_y   : s1_y_q;
    s1_pix_d   = transfer ? sel_pix : s1_pix_q;
  end

  // S2: address/range stage feeding the registered write port.
  always_comb begin
    in_range  = (32'(s1_x_q) < H_RES) && (32'(s1_y_q) < V_RES);
    addr_calc = ADDR_W'(s1_x_q[15:2]) + ADDR_W'(s1_y_q) * ADDR_W'(LINE_WORDS);
    we_d      = s1_valid_q && in_range && !i_frame_start;
    addr_d    = we_d ? addr_calc : addr_q;
    wdata_d   = we_d ? {4{s1_pix_q}} : wdata_q;
    lane_d    = we_d ? (4'b0001 << s1_x_q[1:0]) : lane_q;
    done_d    = we_d && run && (cnt_q == CNT_W'(FRAME_PIX - 1));
    cnt_d     = cnt_q;
    if (i_frame_start) begin
      cnt_d = '0;
    end else if (we_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Leaving RUN keys off the registered done pulse so o_busy drops the cycle after it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      fb_pkg::ST_IDLE: if (i_frame_start) state_d = fb_pkg::ST_RUN;
      fb_pkg::ST_RUN:  if (!i_frame_start && done_q) state_d = fb_pkg::ST_IDLE;
      default:         state_d = fb_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= fb_pkg::ST_IDLE;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_pix_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lane_q     <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_pix_q   <= s1_pix_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lane_q     <= lane_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef FB_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (i_frame_start) begin
      drop_cnt_d = '0;
    end else if (s1_valid_q && !in_range && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = '0;
`endif

  assign o_gnt        = gnt;
  assign o_we         = we_q;
  assign o_addr       = addr_q;
  assign o_wdata      = wdata_q;
  assign o_lane_en    = lane_q;
  assign o_busy       = run;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench: full-size scheduler via vector table + scoreboard, 8x2 build for frame done/restart.
module tb_fb_write_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // full-size instance
  logic        rst, fs;
  logic [3:0]  req;
  logic [63:0] x, y;
  logic [15:0] pix;
  logic [3:0]  gnt;
  logic        we;
  logic [16:0] addr;
  logic [15:0] wdata;
  logic [3:0]  lane;
  logic        busy, done;
  logic [15:0] drop;

  // 8x2 instance
  logic        s_fs;
  logic [3:0]  s_req;
  logic [63:0] s_x, s_y;
  logic [15:0] s_pix;
  logic [3:0]  s_gnt;
  logic        s_we;
  logic [16:0] s_addr;
  logic [15:0] s_wdata;
  logic [3:0]  s_lane;
  logic        s_busy, s_done;
  logic [15:0] s_drop;

  fb_write_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_req(req),
    .i_x(x), .i_y(y), .i_pix(pix), .o_gnt(gnt), .o_we(we), .o_addr(addr),
    .o_wdata(wdata), .o_lane_en(lane), .o_busy(busy), .o_frame_done(done),
    .o_drop_cnt(drop)
  );

  fb_write_scheduler #(
    .NUM_REQ(4), .PIX_W(4), .H_RES(8), .V_RES(2), .ADDR_W(17)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_frame_start(s_fs), .i_req(s_req),
    .i_x(s_x), .i_y(s_y), .i_pix(s_pix), .o_gnt(s_gnt), .o_we(s_we), .o_addr(s_addr),
    .o_wdata(s_wdata), .o_lane_en(s_lane), .o_busy(s_busy), .o_frame_done(s_done),
    .o_drop_cnt(s_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [16:0] addr;
    logic [3:0]  lane;
    logic [15:0] wdata;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [15:0] vx;
    logic [15:0] vy;
    logic [3:0]  vpix;
    bit          vwe;
    logic [16:0] vaddr;
    logic [3:0]  vlane;
  } vec_t;

  exp_t sbq[$];
  bit   mon_en = 1'b0;
  vec_t vecs[9];
  logic [16:0] rr_addr [4];

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && we) begin
      if (sbq.size() == 0) begin
        chk("unexpected_we", 32'(we), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", 32'(addr), 32'(e.addr));
        chk("wr_lane", 32'(lane), 32'(e.lane));
        chk("wr_wdata", 32'(wdata), 32'(e.wdata));
        chk("wr_latency", cyc, e.due);
      end
      chk("no_frame_done", 32'(done), 32'd0);
    end
  end

  task automatic send(input int k, input vec_t v);
    int n = 0;
    req[k]            = 1'b1;
    x[16*k +: 16]     = v.vx;
    y[16*k +: 16]     = v.vy;
    pix[4*k +: 4]     = v.vpix;
    @(negedge clk);
    while (!gnt[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_gnt", 32'(gnt[k]), 32'd1);
    if (gnt[k] && v.vwe) sbq.push_back('{v.vaddr, v.vlane, {4{v.vpix}}, cyc + 2});
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic small_frame(input int n_pix, input int fs_at, input int exp_we, input bit exp_done);
    int we_cnt  = 0;
    int done_at = -100;
    for (int t = -1; t < n_pix + 6; t++) begin
      s_fs        = (t == -1 || t == fs_at);
      s_req       = (t >= 0 && t < n_pix) ? 4'b0001 : 4'b0000;
      s_x[15:0]   = 16'((t >= 0) ? t % 8 : 0);
      s_y[15:0]   = 16'((t >= 0) ? t / 8 : 0);
      s_pix[3:0]  = 4'(t);
      @(negedge clk);
      if (t >= 0 && t < n_pix) chk("s_gnt", 32'(s_gnt), 32'd1);
      if (s_we) we_cnt++;
      if (s_we || s_done) chk("s_done_on_16th", 32'(s_done), 32'(s_we && we_cnt == 16));
      if (s_done) begin
        chk("s_busy_at_done", 32'(s_busy), 32'd1);
        done_at = t;
      end
      if (t == done_at + 1) chk("s_busy_after_done", 32'(s_busy), 32'd0);
      @(posedge clk); #1;
    end
    s_fs = 1'b0;
    chk("s_we_count", 32'(we_cnt), 32'(exp_we));
    chk("s_done_seen", 32'(done_at >= 0), 32'(exp_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_drop;
    int k;
    int exp_drop;

    vecs[0] = '{16'd5,     16'd2,     4'hA, 1'b1, 17'd401,    4'b0010};
    vecs[1] = '{16'd0,     16'd0,     4'h1, 1'b1, 17'd0,      4'b0001};
    vecs[2] = '{16'd799,   16'd599,   4'hF, 1'b1, 17'd119999, 4'b1000};
    vecs[3] = '{16'd800,   16'd0,     4'h3, 1'b0, 17'd0,      4'b0000};
    vecs[4] = '{16'd0,     16'd600,   4'h3, 1'b0, 17'd0,      4'b0000};
    vecs[5] = '{16'd3,     16'd1,     4'h7, 1'b1, 17'd200,    4'b1000};
    vecs[6] = '{16'd4,     16'd0,     4'h2, 1'b1, 17'd1,      4'b0001};
    vecs[7] = '{16'hFFFF,  16'hFFFF,  4'h5, 1'b0, 17'd0,      4'b0000};
    vecs[8] = '{16'd798,   16'd0,     4'h9, 1'b1, 17'd199,    4'b0100};
    rr_addr = '{17'd2000, 17'd2204, 17'd2408, 17'd2612};

    rst = 1'b1; fs = 1'b0; req = 4'b1111; x = '0; y = '0; pix = '0;
    s_fs = 1'b0; s_req = 4'b1111; s_x = '0; s_y = '0; s_pix = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_drop", 32'(drop), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_s_busy", 32'(s_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mon_en = 1'b1; s_req = '0;

    // requests in IDLE are never granted
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_we", 32'(we), 32'd0);
    end
    @(posedge clk); #1;
    req = '0;

    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
    @(negedge clk);
    chk("run_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;

    n_drop = 0;
    for (int i = 0; i < 9; i++) begin
      send(i % 4, vecs[i]);
      if (!vecs[i].vwe) n_drop++;
    end
    drain();
`ifdef FB_DROPCNT_EN
    exp_drop = n_drop;
`else
    exp_drop = 0;
`endif
    @(negedge clk);
    chk("drop_cnt", 32'(drop), 32'(exp_drop));
    @(posedge clk); #1;

    // restart resets pointer to 0 and clears the drop counter
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
    @(negedge clk);
    chk("restart_drop_clear", 32'(drop), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;

    for (int e = 0; e < 4; e++) begin
      x[16*e +: 16] = 16'(17 * e);
      y[16*e +: 16] = 16'(10 + e);
      pix[4*e +: 4] = 4'(e + 1);
    end
    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) req = 4'b0100;
      k = (i < 8) ? i % 4 : 2;
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(1) << k);
      sbq.push_back('{rr_addr[k], 4'(1 << k), {4{4'(k + 1)}}, cyc + 2});
      @(posedge clk); #1;
    end
    req = '0;
    drain();

    // 8x2 build: complete frame, then restart with two pixels in flight, then a full frame
    small_frame(16, -2, 16, 1'b1);
    small_frame(7, 6, 5, 1'b0);
    small_frame(16, -2, 16, 1'b1);

    chk("final_queue_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
